lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side checker for the 16-bit challenge LFSR stream (polynomial x^16+x^14+x^13+x^11+1, taps 15/13/12/10, left shift with feedback into bit 0). It consumes the sequence of 16-bit LFSR states delivered by the UART word assembler and self-synchronises to it. Once locked it predicts each following word and reports matches, mismatches and loss of lock. It sits between the UART RX word path and the response/status logic.

## Interface
- `LOCK_COUNT`, 4: consecutive correct predictions in HUNT required to assert lock (1..15).
- `UNLOCK_MISSES`, 3: consecutive mismatches in LOCKED that drop lock (1..15).
- `CNT_W`, 16: width of the error and word counters.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `in_data` is valid this cycle. No backpressure; the checker accepts every valid word.
- `in_data` in 16: received LFSR state.
- `clr_counts` in 1: synchronous clear of both counters.
- `locked` out 1: checker is in LOCKED.
- `match` out 1: one-cycle pulse when a checked word equals its prediction.
- `mismatch` out 1: one-cycle pulse when a checked word differs from its prediction.
- `lock_lost` out 1: one-cycle pulse on the LOCKED→HUNT transition.
- `err_count` out CNT_W: mismatches counted while LOCKED; saturates at all-ones.
- `word_count` out CNT_W: words checked while LOCKED; saturates at all-ones.

## Operation
- Next-state function: `nxt(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}`.
- Internal registers:
  - `pred`: the expected next word.
  - `run`: a 4-bit counter of consecutive hits or misses.
  - `have_seed`: set once HUNT holds a seed.
- **HUNT** (entered on reset):
  - Valid word with `have_seed`=0: if the word is nonzero, set `pred`=nxt(word), `have_seed`=1, `run`=0. A zero word is ignored.
  - Valid word with `have_seed`=1, word==`pred`: `match` pulses, `run`++, `pred`=nxt(word). When `run` reaches LOCK_COUNT, go to LOCKED, `run`=0.
  - Valid word with `have_seed`=1, word!=`pred`: `mismatch` pulses. Reseed from the word (`pred`=nxt(word), `run`=0), or clear `have_seed` if the word is zero.
- **LOCKED**:
  - Every valid word: `word_count`++.
  - Hit: `match` pulses, `run`=0, `pred`=nxt(pred).
  - Miss: `mismatch` pulses, `err_count`++, `run`++, `pred`=nxt(pred). The checker flywheels on the prediction and never reseeds from bad data.
  - A zero word is always a miss.
  - When `run` reaches UNLOCK_MISSES: `lock_lost` pulses, go to HUNT, `have_seed`=0, `run`=0.
- Counters do not change in HUNT. Both saturate at all-ones.
- If `clr_counts` and a counting event occur in the same cycle, the counter is written to 0; the clear wins.
- Cycles without `in_valid` change no state.

## Timing
- All outputs are registered. A word accepted at edge N produces `match`/`mismatch`, the counter updates and the state change visible after edge N.
- The `locked` rise is concurrent with the LOCK_COUNT-th `match`.
- `lock_lost`, the `locked` fall and the UNLOCK_MISSES-th `mismatch` pulse in the same cycle.
- Back-to-back valid words every cycle are supported at full rate.
- Reset values: `locked`=0, `match`=0, `mismatch`=0, `lock_lost`=0, `err_count`=0, `word_count`=0; `pred`=0, `run`=0, `have_seed`=0, state HUNT.
- Reset asserted mid-stream aborts immediately, whatever the state.

## Configuration
- `LFSR_CHECKER_COUNTERS_EN` defined: `err_count` and `word_count` are implemented as specified.
- Undefined: both outputs are tied to 0, the counter registers are removed and `clr_counts` is ignored. Lock behaviour and all pulses are unchanged.

## Structure
- Shared package `lfsr_pkg`:
  - width constant 16;
  - tap mask 16'hB400 (bits 15/13/12/10);
  - seed constant 16'hACE1;
  - state enum {HUNT, LOCKED};
  - function `lfsr_next`, also used by the generator.
- No sub-module. Next-state logic is the package function; the FSM and counters stay in one module.

## Test plan
- Reset, then words ACE1, 59C3, B387 and the next two states → match pulses at words 2–5; `locked`=1 after the 5th word (seed + 4 hits).
- While locked, corrupt one word (send 0000 in place of the expected value), then resume the correct sequence → one `mismatch`, `err_count`=1, lock held, next correct word gives `match`.
- While locked, send 3 consecutive wrong words → three mismatches, `lock_lost` pulse on the 3rd, `locked`=0, `err_count`=3.
- In HUNT, send ACE1, 1234, then the correct successors of 1234 → reseed on the mismatch at 1234, lock after 4 further hits.
- Send 0000 as the first word after reset → ignored, no pulse, `have_seed` stays 0; ACE1 then seeds normally.
- Assert `clr_counts` in the same cycle as a mismatch while locked → `err_count`=0. Separately, assert `rst` mid-lock → all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit challenge LFSR (x^16+x^14+x^13+x^11+1).
// Used by both the generator and the receive-side checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        HUNT,
        LOCKED
    } lfsr_state_e;

    // Left shift with the tap parity fed into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream from the UART word assembler into the LFSR checker.
interface lfsr_checker_if;
    import lfsr_pkg::*;

    logic              in_valid;
    logic [LFSR_W-1:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input in_valid, input in_data);

endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the challenge LFSR word stream.
// Define LFSR_CHECKER_COUNTERS_EN to implement err_count/word_count; otherwise they read 0.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_MISSES = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    lfsr_checker_if.slave    rx,
    input  logic             clr_counts,
    output logic             locked,
    output logic             match,
    output logic             mismatch,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [3:0] LockCnt   = 4'(LOCK_COUNT);
    localparam logic [3:0] UnlockCnt = 4'(UNLOCK_MISSES);

    lfsr_state_e       state_q, state_d;
    logic [LFSR_W-1:0] pred_q, pred_d;
    logic [3:0]        run_q, run_d;
    logic              have_seed_q, have_seed_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic              lock_lost_q, lock_lost_d;
    logic              word_evt, err_evt;
    logic [3:0]        run_inc;
    logic [LFSR_W-1:0] data;

    assign data    = rx.in_data;
    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        run_d       = run_q;
        have_seed_d = have_seed_q;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        lock_lost_d = 1'b0;
        word_evt    = 1'b0;
        err_evt     = 1'b0;
        if (rx.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (!have_seed_q) begin
                        // The all-zero state is a fixed point of the LFSR, never a usable seed.
                        if (data != '0) begin
                            pred_d      = lfsr_next(data);
                            have_seed_d = 1'b1;
                            run_d       = 4'd0;
                        end
                    end else if (data == pred_q) begin
                        match_d = 1'b1;
                        pred_d  = lfsr_next(data);
                        if (run_inc == LockCnt) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        run_d      = 4'd0;
                        if (data == '0) begin
                            have_seed_d = 1'b0;
                        end else begin
                            pred_d = lfsr_next(data);
                        end
                    end
                end
                LOCKED: begin
                    word_evt = 1'b1;
                    // Flywheel on the prediction; received data never reseeds while locked.
                    pred_d   = lfsr_next(pred_q);
                    if (data == pred_q && data != '0) begin
                        match_d = 1'b1;
                        run_d   = 4'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        err_evt    = 1'b1;
                        if (run_inc == UnlockCnt) begin
                            lock_lost_d = 1'b1;
                            state_d     = HUNT;
                            have_seed_d = 1'b0;
                            run_d       = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            pred_q      <= '0;
            run_q       <= 4'd0;
            have_seed_q <= 1'b0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            run_q       <= run_d;
            have_seed_q <= have_seed_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign match     = match_q;
    assign mismatch  = mismatch_q;
    assign lock_lost = lock_lost_q;

`ifdef LFSR_CHECKER_COUNTERS_EN
    logic [CNT_W-1:0] err_q, word_q;

    // Clear takes priority over a same-cycle count; both saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            word_q <= '0;
        end else if (clr_counts) begin
            err_q  <= '0;
            word_q <= '0;
        end else begin
            if (word_evt && word_q != '1) begin
                word_q <= word_q + CNT_W'(1);
            end
            if (err_evt && err_q != '1) begin
                err_q <= err_q + CNT_W'(1);
            end
        end
    end

    assign err_count  = err_q;
    assign word_count = word_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{clr_counts, word_evt, err_evt};
    assign err_count  = '0;
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Table-driven, scoreboarded bench for lfsr_checker.
// Counter expectations follow LFSR_CHECKER_COUNTERS_EN (zero when undefined).
module tb_lfsr_checker;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        clr;
        logic        m;
        logic        mm;
        logic        lk;
        logic        lost;
        logic [15:0] err;
        logic [15:0] word;
    } vec_t;

`ifdef LFSR_CHECKER_COUNTERS_EN
    localparam bit CountersEn = 1'b1;
`else
    localparam bit CountersEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_counts = 1'b0;
    logic        locked, match, mismatch, lock_lost;
    logic [15:0] err_count, word_count;

    int checks   = 0;
    int failures = 0;

    vec_t exp_q[$];
    vec_t tbl[22];
    logic [15:0] s[12];
    logic [15:0] t[12];

    lfsr_checker_if rx_if ();

    lfsr_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_MISSES(3),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if),
        .clr_counts(clr_counts),
        .locked    (locked),
        .match     (match),
        .mismatch  (mismatch),
        .lock_lost (lock_lost),
        .err_count (err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Independent reference: explicit tap bits 15/13/12/10.
    function automatic logic [15:0] ref_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic vec_t mk(input logic valid, input logic [15:0] data, input logic clr,
                                input logic m, input logic mm, input logic lk, input logic lost,
                                input logic [15:0] err, input logic [15:0] word);
        vec_t v;
        v.valid = valid; v.data = data; v.clr = clr;
        v.m = m; v.mm = mm; v.lk = lk; v.lost = lost;
        v.err = CountersEn ? err : 16'h0;
        v.word = CountersEn ? word : 16'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".match"},      {15'h0, match},     {15'h0, e.m});
        check({tag, ".mismatch"},   {15'h0, mismatch},  {15'h0, e.mm});
        check({tag, ".locked"},     {15'h0, locked},    {15'h0, e.lk});
        check({tag, ".lock_lost"},  {15'h0, lock_lost}, {15'h0, e.lost});
        check({tag, ".err_count"},  err_count,          e.err);
        check({tag, ".word_count"}, word_count,         e.word);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        rx_if.in_valid = v.valid;
        rx_if.in_data  = v.data;
        clr_counts     = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = 16'h0;
        clr_counts     = 1'b0;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = 16'h0;

        s[0] = 16'hACE1;
        t[0] = 16'h1234;
        for (int i = 1; i < 12; i++) begin
            s[i] = ref_next(s[i-1]);
            t[i] = ref_next(t[i-1]);
        end

        //              valid data     clr  m  mm lk lost err word
        tbl[0]  = mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);  // zero first word ignored
        tbl[1]  = mk(1, s[0],     0, 0, 0, 0, 0, 0, 0);  // seed
        tbl[2]  = mk(1, s[1],     0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, s[2],     0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, s[3],     0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, s[4],     0, 1, 0, 1, 0, 0, 0);  // lock with 4th hit
        tbl[6]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 0, 0);  // idle cycle
        tbl[7]  = mk(1, s[5],     0, 1, 0, 1, 0, 0, 1);
        tbl[8]  = mk(1, 16'h0000, 0, 0, 1, 1, 0, 1, 2);  // corrupted word
        tbl[9]  = mk(1, s[7],     0, 1, 0, 1, 0, 1, 3);  // flywheel resumes
        tbl[10] = mk(0, 16'h0000, 1, 0, 0, 1, 0, 0, 0);  // clear counters
        tbl[11] = mk(1, 16'h1111, 0, 0, 1, 1, 0, 1, 1);
        tbl[12] = mk(1, 16'h2222, 0, 0, 1, 1, 0, 2, 2);
        tbl[13] = mk(1, 16'h3333, 0, 0, 1, 0, 1, 3, 3);  // lock lost
        tbl[14] = mk(1, s[0],     0, 0, 0, 0, 0, 3, 3);  // reseed in HUNT
        tbl[15] = mk(1, t[0],     0, 0, 1, 0, 0, 3, 3);  // miss, reseed from 1234
        tbl[16] = mk(1, t[1],     0, 1, 0, 0, 0, 3, 3);
        tbl[17] = mk(1, t[2],     0, 1, 0, 0, 0, 3, 3);
        tbl[18] = mk(1, t[3],     0, 1, 0, 0, 0, 3, 3);
        tbl[19] = mk(1, t[4],     0, 1, 0, 1, 0, 3, 3);  // relock
        tbl[20] = mk(1, 16'h0000, 1, 0, 1, 1, 0, 0, 0);  // clear beats count
        tbl[21] = mk(1, t[6],     0, 1, 0, 1, 0, 0, 1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", mk(0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset while locked with a match pulse showing.
        rst = 1'b1;
        #1;
        check_outputs("async_rst", mk(0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Seed was dropped by reset: next word only seeds, the one after matches.
        apply("post_rst_seed",  mk(1, t[7], 0, 0, 0, 0, 0, 0, 0));
        apply("post_rst_match", mk(1, t[8], 0, 1, 0, 0, 0, 0, 0));
        apply("post_rst_miss",  mk(1, t[8], 0, 0, 1, 0, 0, 0, 0));

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
